nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Adds two WIDTH-bit operands one 4-bit slice per clock, least-significant slice first.
//  Uses an internal 4-bit carry-lookahead slice; the slice carry-out is registered as the next slice's carry-in.
//  Operands arrive on a valid/ready input channel; sum, carry and overflow leave on a valid/ready output channel.
//  Used where a full-width CLA is too large and an operation latency of WIDTH/4 cycles is acceptable.
// PARAMETERS
//  WIDTH   16   operand/sum width in bits; must be a multiple of 4 and >= 8
//  NIB     WIDTH/4 (localparam)   slice count; counter width is clog2(NIB)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      a, b and cin are valid
//  in_ready   out  1      block accepts an operand set this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry into bit 0
//  out_valid  out  1      sum, cout and ovf are valid
//  out_ready  in   1      consumer takes the result this cycle
//  sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//  busy       out  1      high in ADD and DONE states
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, count=0, carry_reg=0
//   - operand and sum registers cleared
//   - sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE)
//  FSM states:
//   - IDLE: in_ready=1. If in_valid, capture a->a_sh, b->b_sh, cin->carry_reg, count=0; go to ADD.
//   - ADD: in_ready=0.
//     - Slice inputs: a_sh[3:0], b_sh[3:0], carry_reg.
//     - Full CLA lookahead inside the slice: P=a^b, G=a&b, C1..C4 in two-level logic. No internal ripple.
//     - Each edge: slice sum enters sum_sh at [WIDTH-1:WIDTH-4] and sum_sh shifts right 4.
//     - a_sh and b_sh shift right 4. carry_reg<=C4. count++.
//     - When count==NIB-1: also latch cout<=C4 and ovf<=C3^C4, then go to DONE.
//   - DONE: out_valid=1 and sum=sum_sh. Outputs stay stable while out_ready=0. When out_ready=1, go to IDLE.
//  Output timing:
//   - sum/cout/ovf are registered and change only on the edge entering DONE.
//   - They hold their last values in IDLE; only out_valid qualifies them.
//  Latency and throughput:
//   - out_valid rises NIB edges after the accepting edge.
//   - One result per NIB+2 cycles with out_ready tied high (bubble in IDLE).
//  Handshake rules:
//   - in_ready is low in ADD and DONE; a, b and cin are ignored there.
//   - in_valid held high across DONE->IDLE is accepted in the IDLE cycle.
//   - in_ready does not depend combinationally on out_ready.
//  Simultaneous events: the DONE-cycle out_ready takes priority; the new operand is taken next cycle in IDLE.
//  Width rules:
//   - sum is exactly (a+b+cin) mod 2^WIDTH and cout is bit WIDTH of the full sum.
//   - All operands are unsigned; ovf is the two's-complement interpretation only.
//  Reset mid-operation: async return to reset values. The partial result is discarded and no out_valid pulse occurs.
//  Counter: saturates by state change only and never wraps within an operation.
// TESTING (WIDTH=16)
//  1. Basic add, out_ready=1:
//     - a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0.
//     - out_valid rises 4 edges after accept.
//  2. Carry across slices: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
//  3. Full propagate chain: a=0x0F0F, b=0xF0F0, cin=1 -> sum=0x0000, cout=1, ovf=0.
//  4. Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
//     Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
//  5. Back-pressure: case 1 with out_ready=0 for 5 cycles after out_valid.
//     - sum, cout and out_valid hold; in_ready stays 0.
//     - Accept on out_ready=1, then IDLE with in_ready=1.
//  6. Reset mid-ADD: assert rst_n=0 after 2 slices of case 2.
//     - sum=0, out_valid=0 immediately (async).
//     - No result is ever produced; the next operand set after release computes correctly.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder built from one 4-bit carry-lookahead slice, one slice per clock, LSB slice first
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_sh_q, sum_sh_d, sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [3:0]       p, g, s;
  logic [4:0]       c;

  // 4-bit lookahead slice: every carry is a flat sum of products, no ripple between bits
  always_comb begin
    p    = a_q[3:0] ^ b_q[3:0];
    g    = a_q[3:0] & b_q[3:0];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
  end

  // sequencing: capture in IDLE, shift one slice per cycle in ADD, hold the result in DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        sum_sh_d = {s, sum_sh_q[WIDTH-1:4]};
        carry_d  = c[4];
        if (cnt_q == CW'(NIB - 1)) begin
          sum_d   = sum_sh_d;
          cout_d  = c[4];
          ovf_d   = c[3] ^ c[4];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously so an interrupted add leaves no trace
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random adds against an arithmetic reference, with back-pressure and mid-add reset
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout, ovf, busy;
  int          total = 0;
  int          passed = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // reference: plain integer arithmetic; signed overflow means the signed sum leaves the 16-bit range
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] full;
    int          ssum;
    full = {1'b0, x} + {1'b0, y} + {16'd0, c};
    ssum = int'($signed(x)) + int'($signed(y)) + int'(c);
    return {(ssum > 32767 || ssum < -32768), full};
  endfunction

  task automatic do_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                       input logic xc, input int hold);
    logic [17:0] exp;
    int          lat;
    exp = model(xa, xb, xc);
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~xa; b = xb ^ 16'h5a5a; cin = ~xc;
    chk({tag, ".busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, 4);
    chk({tag, ".sum"}, sum, exp[15:0]);
    chk({tag, ".cout"}, cout, exp[16]);
    chk({tag, ".ovf"}, ovf, exp[17]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_sum"}, sum, exp[15:0]);
      chk({tag, ".hold_cout"}, cout, exp[16]);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".post_valid"}, out_valid, 0);
    chk({tag, ".post_in_ready"}, in_ready, 1);
    chk({tag, ".post_sum_held"}, sum, exp[15:0]);
  endtask

  initial begin
    #2;
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("basic", 16'h1234, 16'h4321, 1'b0, 0);
    do_op("carry", 16'hFFFF, 16'h0001, 1'b0, 0);
    do_op("propagate", 16'h0F0F, 16'hF0F0, 1'b1, 0);
    do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 0);
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 0);
    do_op("backpressure", 16'h1234, 16'h4321, 1'b0, 5);
    // reset after two slices of an add: everything drops at once and no result ever appears
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.sum", sum, 0);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst.no_result", out_valid, 0);
    end
    do_op("after_rst", 16'hABCD, 16'h1111, 1'b1, 0);
    for (int i = 0; i < 10; i++)
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
